// File: rtl/fft_mag_writer_if.sv
// FFT beat stream bundle: one 32-bit beat per handshake, {re[31:16], im[15:0]},
// with tlast marking the final bin of a frame.
interface fft_mag_writer_if;
  logic [31:0] fft_tdata;
  logic        fft_tvalid;
  logic        fft_tlast;
  logic        fft_tready;

  modport master (
    output fft_tdata,
    output fft_tvalid,
    output fft_tlast,
    input  fft_tready
  );

  modport slave (
    input  fft_tdata,
    input  fft_tvalid,
    input  fft_tlast,
    output fft_tready
  );
endinterface

// File: rtl/fft_mag_writer.sv
// FFT magnitude writer: converts each complex FFT bin to an alpha-max/beta-min
// magnitude estimate and writes one frame of NBINS bins into a BRAM, then hands
// the frame to an energy reader via a ready/done handshake. The input stream is
// never back-pressured; beats that cannot be used are accepted and dropped.
module fft_mag_writer #(
  parameter int NBINS = 512
) (
  input  logic                  clock,
  input  logic                  reset_n,
  fft_mag_writer_if.slave       fft,
  input  logic                  done,
  output logic                  ready,
  output logic                  bram_we,
  output logic [9:0]            bram_waddr,
  output logic [15:0]           bram_wdata,
  output logic [7:0]            frames_dropped,
  output logic                  err_short
);

  localparam int              DATA_W   = 16;
  localparam logic [10:0]     NBINS_L  = 11'(NBINS);
  localparam logic [10:0]     LAST_IDX = 11'(NBINS - 1);

  typedef enum logic [2:0] {
    SYNC,
    WRITE,
    DRAIN,
    HANDOFF,
    WAIT_DONE
  } state_t;

  state_t                     state;
  logic [9:0]                 k;
  logic                       drain_cnt;
  logic                       in_frame;
  logic                       tready_r;

  logic                       acc_p0;
  logic                       last_p0;
  logic                       in_range_p0;
  logic                       wr_p0;
  logic                       nxt_in_frame;
  logic signed [DATA_W-1:0]   re_p0;
  logic signed [DATA_W-1:0]   im_p0;

  logic [DATA_W:0]            a_p1;
  logic [DATA_W:0]            b_p1;
  logic [9:0]                 addr_p1;
  logic                       vld_p1;

  // |v| widened by one bit so that |-32768| = 32768 is representable.
  function automatic logic [DATA_W:0] abs_s(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W:0] ext;
    ext = {v[DATA_W-1], v};
    return v[DATA_W-1] ? 17'(-ext) : 17'(ext);
  endfunction

  // max(a,b) + min(a,b)/2, carried with headroom for the saturation stage.
  function automatic logic [DATA_W+1:0] mag_est(input logic [DATA_W:0] a,
                                                input logic [DATA_W:0] b);
    logic [DATA_W:0] mx;
    logic [DATA_W:0] mn;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return {1'b0, mx} + {2'b00, mn[DATA_W:1]};
  endfunction

  // Clamp to the 16-bit unsigned BRAM word.
  function automatic logic [DATA_W-1:0] sat_u16(input logic [DATA_W+1:0] v);
    return (v > 18'h0FFFF) ? 16'hFFFF : v[DATA_W-1:0];
  endfunction

  assign fft.fft_tready = tready_r;
  assign acc_p0         = fft.fft_tvalid & tready_r;
  assign last_p0        = fft.fft_tlast;
  assign re_p0          = fft.fft_tdata[31:16];
  assign im_p0          = fft.fft_tdata[15:0];
  assign in_range_p0    = ({1'b0, k} < NBINS_L);
  assign wr_p0          = acc_p0 && (state == WRITE) && in_range_p0;
  // Tracks whether the stream is between a first beat and its tlast, so a
  // frame that began while the reader held the BRAM is never half-written.
  assign nxt_in_frame   = acc_p0 ? ~last_p0 : in_frame;

  // Frame sequencing FSM with registered handshake and status outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= SYNC;
      k              <= 10'd0;
      drain_cnt      <= 1'b0;
      in_frame       <= 1'b0;
      tready_r       <= 1'b0;
      ready          <= 1'b0;
      err_short      <= 1'b0;
      frames_dropped <= 8'd0;
    end else begin
      tready_r  <= 1'b1;
      err_short <= 1'b0;
      in_frame  <= nxt_in_frame;
      if ((state == HANDOFF || state == WAIT_DONE) && acc_p0 && last_p0 &&
          frames_dropped != 8'hFF) begin
        frames_dropped <= frames_dropped + 8'd1;
      end
      case (state)
        SYNC: begin
          if (acc_p0 && last_p0) begin
            state <= WRITE;
            k     <= 10'd0;
          end
        end
        WRITE: begin
          if (acc_p0) begin
            if (last_p0) begin
              k <= 10'd0;
              if ({1'b0, k} >= LAST_IDX) begin
                state     <= DRAIN;
                drain_cnt <= 1'b0;
              end else begin
                err_short <= 1'b1;
              end
            end else if (k != 10'h3FF) begin
              k <= k + 10'd1;
            end
          end
        end
        DRAIN: begin
          // Two cycles let the final in-range beat leave the magnitude pipeline.
          if (drain_cnt) begin
            state <= HANDOFF;
            ready <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        HANDOFF: begin
          if (!done) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done) begin
            ready <= 1'b0;
            k     <= 10'd0;
            state <= nxt_in_frame ? SYNC : WRITE;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  // Stage 0 -> 1: absolute values of the accepted beat and its target address.
  always_ff @(posedge clock) begin
    a_p1    <= abs_s(re_p0);
    b_p1    <= abs_s(im_p0);
    addr_p1 <= k;
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= wr_p0;
  end

  // Stage 1 -> 2: magnitude estimate, saturation and BRAM write port.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bram_we    <= 1'b0;
      bram_waddr <= 10'd0;
      bram_wdata <= 16'd0;
    end else begin
      bram_we <= vld_p1;
      if (vld_p1) begin
        bram_waddr <= addr_p1;
        bram_wdata <= sat_u16(mag_est(a_p1, b_p1));
      end
    end
  end

endmodule
